// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path.
//   UART_DATA_WIDTH_DEFAULT    : default byte width (matches the transmitter)
//   UART_TX_FIFO_DEPTH_DEFAULT : default number of FIFO entries
//   tx_entry_t                 : {error, data} entry layout at the default width
// The FIFO stores entries as a DATA_WIDTH+1 packed vector with the same
// layout, so non-default widths work without this struct.
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_DATA_WIDTH_DEFAULT    = 8;
  localparam int UART_TX_FIFO_DEPTH_DEFAULT = 16;

  typedef struct packed {
    logic       error;
    logic [7:0] data;
  } tx_entry_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// ---------------------------------------------------------------------------
// uart_fifo_mem
// DEPTH x WIDTH storage with one synchronous write port and one
// asynchronous (combinational) read port. Contents are not reset.
// Ports:
//   clk   : clock
//   we    : write enable
//   waddr : write index
//   wdata : write entry
//   raddr : read index
//   rdata : entry at raddr (combinational)
// ---------------------------------------------------------------------------
module uart_fifo_mem #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
// Show-ahead FIFO between the host and the UART transmitter. Each entry is a
// data byte plus an error-injection flag forwarded to the transmitter.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   wr_valid/wr_data/
//   wr_error/wr_ready     : host write handshake (push on wr_valid&&wr_ready)
//   tx_valid/tx_data/
//   tx_error/tx_ready     : transmitter handshake (pop on tx_valid&&tx_ready)
//   count                 : number of stored entries, 0..DEPTH
//   full, empty           : status derived from the registered pointers
//   overflow              : sticky, set when a write is attempted while full
//   clr_overflow          : synchronous clear of overflow (set wins)
// ---------------------------------------------------------------------------
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH_DEFAULT,
  parameter int DEPTH      = UART_TX_FIFO_DEPTH_DEFAULT,
  localparam int AW        = $clog2(DEPTH),
  localparam int PW        = AW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_error,
  output logic                  wr_ready,
  output logic                  tx_valid,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_error,
  input  logic                  tx_ready,
  output logic [PW-1:0]         count,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  input  logic                  clr_overflow
);

  localparam int EW = DATA_WIDTH + 1;

  // Pointers carry one extra wrap bit above the index bits.
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] rd_entry;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  // Pointer difference modulo 2*DEPTH gives the occupancy directly.
  assign count = wr_ptr - rd_ptr;

  // wr_ready ignores a same-cycle pop: no write-through when full.
  assign wr_ready = !full;
  assign tx_valid = !empty;
  assign push     = wr_valid && wr_ready;
  assign pop      = tx_valid && tx_ready;

  assign wr_entry = {wr_error, wr_data};

  uart_fifo_mem #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wr_entry),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_entry)
  );

  // Head entry is masked while empty so stale storage never reaches the
  // transmitter; the array itself is not reset.
  assign tx_data  = empty ? '0   : rd_entry[DATA_WIDTH-1:0];
  assign tx_error = empty ? 1'b0 : rd_entry[DATA_WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (wr_valid && full) begin
      overflow <= 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int PW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_error;
  logic          wr_ready;
  logic          tx_valid;
  logic [DW-1:0] tx_data;
  logic          tx_error;
  logic          tx_ready;
  logic [PW-1:0] count;
  logic          full;
  logic          empty;
  logic          overflow;
  logic          clr_overflow;

  int checks   = 0;
  int failures = 0;

  // Scoreboard of {error, data} in expected output order, plus model overflow.
  logic [DW:0] sb [$];
  logic        m_ovf;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_valid     (wr_valid),
    .wr_data      (wr_data),
    .wr_error     (wr_error),
    .wr_ready     (wr_ready),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_error     (tx_error),
    .tx_ready     (tx_ready),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare all DUT outputs against the model's current state.
  task automatic chk_state(input string tag);
    int n;
    n = sb.size();
    chk({tag, ":count"},    32'(count),    32'(n));
    chk({tag, ":empty"},    32'(empty),    32'(n == 0));
    chk({tag, ":full"},     32'(full),     32'(n == DEPTH));
    chk({tag, ":wr_ready"}, 32'(wr_ready), 32'(n != DEPTH));
    chk({tag, ":tx_valid"}, 32'(tx_valid), 32'(n != 0));
    chk({tag, ":overflow"}, 32'(overflow), 32'(m_ovf));
    if (n > 0) begin
      chk({tag, ":tx_data"},  32'(tx_data),  32'(sb[0][DW-1:0]));
      chk({tag, ":tx_error"}, 32'(tx_error), 32'(sb[0][DW]));
    end else begin
      chk({tag, ":tx_data"},  32'(tx_data),  32'h0);
      chk({tag, ":tx_error"}, 32'(tx_error), 32'h0);
    end
  endtask

  // Check state, apply the model update for the current inputs, advance one clock.
  task automatic cyc(input string tag);
    bit was_full;
    bit do_push;
    bit do_pop;
    chk_state(tag);
    was_full = (sb.size() == DEPTH);
    do_push  = wr_valid && !was_full;
    do_pop   = tx_ready && (sb.size() != 0);
    if (do_pop)  void'(sb.pop_front());
    if (do_push) sb.push_back({wr_error, wr_data});
    if (wr_valid && was_full) m_ovf = 1'b1;
    else if (clr_overflow)    m_ovf = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] held;
    rst = 1'b1; wr_valid = 1'b0; wr_data = '0; wr_error = 1'b0;
    tx_ready = 1'b0; clr_overflow = 1'b0; m_ovf = 1'b0;

    // 1. reset held for 3 cycles
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_state("reset");
    chk("reset:count_lit", 32'(count), 32'h0);

    // 2. single byte, held under back-pressure, then popped
    wr_valid = 1'b1; wr_data = 8'hA5; wr_error = 1'b0;
    cyc("single_push");
    wr_valid = 1'b0;
    chk("single:tx_data_lit", 32'(tx_data), 32'hA5);
    chk("single:count_lit",   32'(count),   32'h1);
    held = tx_data;
    for (int i = 0; i < 10; i++) cyc("single_hold");
    chk("single:stable", 32'(tx_data), 32'(held));
    tx_ready = 1'b1;
    cyc("single_pop");
    tx_ready = 1'b0;
    chk("single:empty_lit", 32'(empty), 32'h1);

    // 3. fill, overflow, set-beats-clear, drain, clear
    for (int i = 0; i < DEPTH; i++) begin
      wr_valid = 1'b1; wr_data = 8'(i); wr_error = 1'b0;
      cyc("fill");
    end
    chk("fill:full_lit",     32'(full),     32'h1);
    chk("fill:count_lit",    32'(count),    32'h10);
    chk("fill:wr_ready_lit", 32'(wr_ready), 32'h0);
    wr_data = 8'hFF;
    cyc("ovf_push");
    chk("ovf:flag_lit",  32'(overflow), 32'h1);
    chk("ovf:count_lit", 32'(count),    32'h10);
    clr_overflow = 1'b1;
    cyc("ovf_set_wins");
    chk("ovf:set_wins_lit", 32'(overflow), 32'h1);
    wr_valid = 1'b0; clr_overflow = 1'b0;
    tx_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain:order_lit", 32'(tx_data), 32'(i));
      cyc("drain");
    end
    tx_ready = 1'b0;
    chk("drain:empty_lit", 32'(empty), 32'h1);
    clr_overflow = 1'b1;
    cyc("ovf_clear");
    clr_overflow = 1'b0;
    chk("ovf:cleared_lit", 32'(overflow), 32'h0);

    // 4. error flag travels with its byte
    wr_valid = 1'b1; wr_data = 8'h3C; wr_error = 1'b1;
    cyc("err_push1");
    wr_data = 8'h3D; wr_error = 1'b0;
    cyc("err_push2");
    wr_valid = 1'b0;
    chk("err:first_err_lit",  32'(tx_error), 32'h1);
    chk("err:first_data_lit", 32'(tx_data),  32'h3C);
    tx_ready = 1'b1;
    cyc("err_pop1");
    chk("err:second_err_lit",  32'(tx_error), 32'h0);
    chk("err:second_data_lit", 32'(tx_data),  32'h3D);
    cyc("err_pop2");
    tx_ready = 1'b0;

    // 5. steady push+pop at count 5 across several wraps
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1; wr_data = 8'(8'h80 + i); wr_error = 1'(i & 1);
      cyc("pp_prefill");
    end
    tx_ready = 1'b1;
    for (int i = 5; i < 45; i++) begin
      wr_data = 8'(8'h80 + i); wr_error = 1'(i & 1);
      cyc("pp_stream");
    end
    chk("pp:count_lit",    32'(count),    32'h5);
    chk("pp:overflow_lit", 32'(overflow), 32'h0);
    chk("pp:head_lit",     32'(tx_data),  32'h80 + 32'd40);

    // 6. asynchronous reset mid-operation at count 9
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_data = 8'(8'h80 + 45 + i);
      cyc("pre_rst_fill");
    end
    wr_valid = 1'b0;
    chk("pre_rst:count_lit", 32'(count), 32'h9);
    #2;
    rst = 1'b1;
    #1;
    sb.delete();
    m_ovf = 1'b0;
    chk_state("async_rst");
    chk("async_rst:tx_valid_lit", 32'(tx_valid), 32'h0);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    wr_valid = 1'b1; wr_data = 8'h55; wr_error = 1'b0;
    cyc("post_rst_push");
    wr_valid = 1'b0;
    chk("post_rst:first_lit", 32'(tx_data), 32'h55);
    tx_ready = 1'b1;
    cyc("post_rst_pop");
    tx_ready = 1'b0;
    chk_state("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
